// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, width defaults and
// requester indices.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. last_grant is the index of the requester
// granted most recently; on a tie the other one wins.
module rr_arb2
  import sram_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    grant[REQ_A] = valid[REQ_A] & (~valid[REQ_B] |  last_grant);
    grant[REQ_B] = valid[REQ_B] & (~valid[REQ_A] | ~last_grant);
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for a single-port SRAM. One transaction in flight:
// IDLE accepts, ACCESS pulses the SRAM, RESP returns the response.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_rw,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       owner;
  logic [1:0] grant;
  logic       accept;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_nxt = state;
    rsp_valid = '0;
    rsp_rdata = '0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        state_nxt        = ST_IDLE;
        rsp_valid[owner] = 1'b1;
        // SRAM read data is registered, so it is valid during RESP.
        if (mem_rw) rsp_rdata = mem_data_out;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The mem_* registers double as the captured request; they hold between
  // transactions and only mem_enable is cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      state      <= state_nxt;
      mem_enable <= accept;
      if (accept) begin
        owner       <= grant[REQ_B];
        last_grant  <= grant[REQ_B];
        mem_rw      <= grant[REQ_B] ? req_rw[REQ_B] : req_rw[REQ_A];
        mem_address <= grant[REQ_B] ? req_addr1     : req_addr0;
        mem_data_in <= grant[REQ_B] ? req_wdata1    : req_wdata0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural registered-read SRAM.
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_rw = '0;
  logic [5:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0] req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic       mem_enable, mem_rw;
  logic [5:0] mem_address;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rw       (req_rw),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_wdata0   (req_wdata0),
    .req_wdata1   (req_wdata1),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  // SRAM model: read data registered one cycle after the read is sampled.
  logic [7:0] sram [64];
  always @(posedge clk or posedge reset) begin
    if (reset) mem_data_out <= '0;
    else if (mem_enable && mem_rw) mem_data_out <= sram[mem_address];
  end
  always @(posedge clk) begin
    if (!reset && mem_enable && !mem_rw) sram[mem_address] <= mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic rw, input logic [5:0] a, input logic [7:0] d);
    req_valid[id] = 1'b1;
    req_rw[id]    = rw;
    if (id == 0) begin req_addr0 = a; req_wdata0 = d; end
    else         begin req_addr1 = a; req_wdata1 = d; end
  endtask

  // Waits (bounded) for req_ready on the mask; call just after a negedge.
  task automatic wait_ready(input logic [1:0] mask, output bit got);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if ((req_ready & mask) != 2'b00) begin got = 1; break; end
      @(negedge clk);
    end
  endtask

  // Single transaction; checks ACCESS pins, response at accept+2, then idle.
  task automatic issue(input int id, input logic rw, input logic [5:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
    bit got;
    logic [1:0] own;
    own = (id == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    set_req(id, rw, a, d);
    wait_ready(own, got);
    chk("accept_wait", 32'(got), 1);
    chk("ready_onehot", 32'(req_ready), 32'(own));
    @(posedge clk); #1 req_valid[id] = 1'b0;
    @(negedge clk);
    chk("acc_en", 32'(mem_enable), 1);
    chk("acc_rw", 32'(mem_rw), 32'(rw));
    chk("acc_addr", 32'(mem_address), 32'(a));
    if (!rw) chk("acc_wdata", 32'(mem_data_in), 32'(d));
    chk("acc_rspv", 32'(rsp_valid), 0);
    chk("acc_busy", 32'(busy), 1);
    @(negedge clk);
    chk("resp_v", 32'(rsp_valid), 32'(own));
    chk("resp_data", 32'(rsp_rdata), 32'(exp));
    chk("resp_en", 32'(mem_enable), 0);
    chk("resp_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("post_v", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    bit got;
    int n_acc, n_en, last;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(mem_enable), 0);
    chk("rst_rw", 32'(mem_rw), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_wd", 32'(mem_data_in), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_rd", 32'(rsp_rdata), 0);
    @(negedge clk); reset = 1'b0;

    // Tie right after reset: A, B, A, B
    @(negedge clk);
    set_req(0, 1'b0, 6'd1, 8'h11);
    set_req(1, 1'b0, 6'd2, 8'h22);
    for (int k = 0; k < 4; k++) begin
      wait_ready(2'b11, got);
      chk("rr_wait", 32'(got), 1);
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); @(negedge clk);
      if (k == 3) req_valid = 2'b00;
    end
    repeat (3) @(negedge clk);
    chk("rr_idle", 32'(busy), 0);

    // A write then read back at address 0
    issue(0, 1'b0, 6'd0, 8'hAA, 8'h00);
    issue(0, 1'b1, 6'd0, 8'h00, 8'hAA);

    // B at the top address; rsp_valid[0] must stay clear (checked inside)
    issue(1, 1'b0, 6'd63, 8'h55, 8'h00);
    issue(1, 1'b1, 6'd63, 8'h00, 8'h55);

    // Back-to-back A writes: accepts 3 cycles apart, one enable each
    @(posedge clk); #1 set_req(0, 1'b0, 6'd7, 8'h77);
    n_acc = 0; n_en = 0; last = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (mem_enable) n_en++;
      if (req_ready[0]) begin
        if (n_acc > 0) chk("b2b_gap", 32'(c - last), 3);
        last = c; n_acc++;
        if (n_acc == 3) begin @(posedge clk); #1 req_valid[0] = 1'b0; end
      end
    end
    chk("b2b_acc", 32'(n_acc), 3);
    chk("b2b_en", 32'(n_en), 3);

    // Reset during ACCESS of a read
    @(negedge clk);
    set_req(0, 1'b1, 6'd63, 8'h00);
    wait_ready(2'b01, got);
    chk("rst_acc_wait", 32'(got), 1);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_en", 32'(mem_enable), 0);
    chk("mid_addr", 32'(mem_address), 0);
    chk("mid_rw", 32'(mem_rw), 0);
    chk("mid_rspv", 32'(rsp_valid), 0);
    chk("mid_rd", 32'(rsp_rdata), 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    n_en = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) n_en++;
    end
    chk("mid_no_rsp", 32'(n_en), 0);
    issue(0, 1'b1, 6'd0, 8'h00, 8'hAA);

    // A holds a new request through ACCESS/RESP of the previous one
    @(negedge clk);
    set_req(0, 1'b0, 6'd20, 8'h3C);
    wait_ready(2'b01, got);
    chk("hold_wait", 32'(got), 1);
    @(posedge clk); #1 set_req(0, 1'b0, 6'd21, 8'hC3);
    @(negedge clk);
    chk("hold_rdy_acc", 32'(req_ready), 0);
    chk("hold_addr1", 32'(mem_address), 20);
    @(negedge clk);
    chk("hold_rdy_resp", 32'(req_ready), 0);
    chk("hold_rsp1", 32'(rsp_valid), 1);
    @(negedge clk); #1;
    chk("hold_rdy_idle", 32'(req_ready), 1);
    chk("hold_no_dup", 32'(rsp_valid), 0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("hold_addr2", 32'(mem_address), 21);
    chk("hold_data2", 32'(mem_data_in), 8'hC3);
    @(negedge clk);
    chk("hold_rsp2", 32'(rsp_valid), 1);
    n_en = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) n_en++;
    end
    chk("hold_single", 32'(n_en), 0);
    issue(0, 1'b1, 6'd21, 8'h00, 8'hC3);
    issue(0, 1'b1, 6'd20, 8'h00, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the SRAM word-address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the SRAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid[1:0]  input  2  SHALL carry per-requester request valid; index 0 = requester A, index 1 = requester B.
REQ-006 req_rw[1:0]  input  2  SHALL carry per-requester operation select: 1 = read, 0 = write.
REQ-007 req_addr0, req_addr1  input  ADDR_W each  SHALL carry per-requester word address.
REQ-008 req_wdata0, req_wdata1  input  DATA_W each  SHALL carry per-requester write data.
REQ-009 req_ready[1:0]  output  2  SHALL signal request acceptance; a request transfers when valid and ready are both high at a rising edge.
REQ-010 rsp_valid[1:0]  output  2  SHALL pulse for one cycle per completed transaction, to the owning requester only.
REQ-011 rsp_rdata  output  DATA_W  SHALL carry read data, qualified by rsp_valid.
REQ-012 mem_enable, mem_rw  output  1 each  SHALL drive the SRAM enable and rw (1 = read) pins.
REQ-013 mem_address  output  ADDR_W; mem_data_in  output  DATA_W  SHALL drive the SRAM address and write-data pins.
REQ-014 mem_data_out  input  DATA_W  SHALL receive SRAM read data, which is registered inside the SRAM one cycle after a read is sampled.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-017 In IDLE, req_ready SHALL be asserted combinationally to exactly one requester, the arbitration winner, and only when that requester's valid is high.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of history.
REQ-019 last_grant SHALL update only on an accepted transfer.
REQ-020 On acceptance, the FSM SHALL capture owner, rw, addr and wdata into registers and move IDLE -> ACCESS.
REQ-021 In ACCESS, the block SHALL hold mem_enable = 1 for exactly one cycle with the captured rw, address and data, then move to RESP.
REQ-022 In RESP, rsp_valid[owner] SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-023 For reads, rsp_rdata in RESP SHALL equal mem_data_out; for writes, rsp_rdata SHALL be 0 (write acknowledge).
REQ-024 Latency SHALL be accept edge + 2 cycles to rsp_valid; throughput SHALL be one transaction per 3 cycles.
REQ-025 Outside ACCESS, mem_enable SHALL be 0, and mem_rw, mem_address and mem_data_in SHALL hold their last values.
REQ-026 req_ready SHALL be 0 in ACCESS and RESP; new requests SHALL wait and are never dropped or reordered per requester.
REQ-027 Address and data SHALL pass through unmodified with no wrap or arithmetic; all ADDR_W values (0..63 by default) are legal.

Reset
REQ-028 Reset SHALL force the following: state = IDLE; last_grant = 1 (so A wins the first tie); mem_enable = 0; mem_rw = 0; mem_address = 0; mem_data_in = 0; rsp_valid = 0; rsp_rdata = 0; busy = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no rsp_valid issued; after release, the SRAM contents are unspecified for an interrupted write.

Structure
REQ-030 Package sram_ctrl_pkg SHALL hold the FSM state encoding, the ADDR_W/DATA_W defaults and the requester-index constants.
REQ-031 Round-robin grant logic SHALL live in sub-module rr_arb2 (inputs: valid[1:0], last_grant; output: one-hot grant[1:0]).
REQ-032 The SRAM SHALL be instantiated outside this block, with its reset tied to the same reset.

Verification
REQ-033 A writes 0xAA to address 0, then reads address 0 -> two write rsp_valid[0] pulses at accept+2, and read rsp_rdata = 0xAA.
REQ-034 A and B both valid in the same cycle after reset -> A is granted first and B second; alternation continues while both stay valid (A, B, A, B).
REQ-035 B writes 0x55 to address 63, then reads address 63 -> rsp_rdata = 0x55; rsp_valid[0] stays 0 throughout.
REQ-036 Back-to-back requests from A only -> accepts exactly 3 cycles apart; mem_enable high exactly one cycle per transaction.
REQ-037 Reset asserted during ACCESS of a read -> no rsp_valid; all outputs at reset values; next request completes normally.
REQ-038 A holds valid with req_ready low during RESP -> A's address and data are accepted unchanged on return to IDLE, with no duplicate response.
